// File: rtl/uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder
//   Byte-level command responder sitting behind a UART rx/tx pair. Parses
//   host frames from the received byte stream, services reads and writes to
//   an internal register file and returns exactly one response byte per
//   completed frame.
//
//   Frames:  'R',addr       -> reply reg[addr]
//            'W',addr,data  -> write reg[addr], reply 'K'
//            anything else  -> reply 'E'
//   An address byte with bits set above ADDR_WIDTH completes the frame
//   normally (a W frame still consumes its data byte), writes nothing and
//   replies 'E'.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   one-cycle strobe per received byte
//   tx_ready   transmitter idle (high = may accept tx_start)
//   tx_start   one-cycle request to send tx_data
//   tx_data    response byte, stable from tx_start until the next load
//   wr_strobe  one-cycle pulse when a register write commits
//   wr_addr    address of the committed write
//   wr_data    data of the committed write
//   busy       high whenever the FSM is not in IDLE
//   err_pulse  one-cycle pulse on inter-byte timeout, or on an rx byte that
//              arrives while a response is in flight (that byte is dropped)
//
// Transmit handshake: in SEND the FSM waits for tx_ready=1 and then raises
// tx_start for exactly one cycle. It then waits for tx_ready to fall (the
// transmitter took the byte) and to rise again (the byte has gone out)
// before returning to IDLE, so a new frame is never answered while the
// previous reply is still on the wire.
// ---------------------------------------------------------------------------
module uart_cmd_responder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  wr_strobe,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  err_pulse
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'h52);
  localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'h57);
  localparam logic [DATA_WIDTH-1:0] RSP_OK    = DATA_WIDTH'(8'h4B);
  localparam logic [DATA_WIDTH-1:0] RSP_ERR   = DATA_WIDTH'(8'h45);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ADDR  = 3'd1,
    GET_DATA  = 3'd2,
    SEND      = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

  state_t                  state;
  logic                    cmd_is_write;
  logic                    addr_bad;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]        to_cnt;
  logic [DATA_WIDTH-1:0]   reg_file [NUM_REGS];

  // Address bits above the register file size must all be zero.
  logic rx_addr_bad;
  assign rx_addr_bad = |rx_data[DATA_WIDTH-1:ADDR_WIDTH];

  // A byte arriving while a reply is pending or in flight is dropped.
  logic responding;
  assign responding = (state == SEND) || (state == WAIT_BUSY) || (state == WAIT_DONE);

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd_is_write <= 1'b0;
      addr_bad     <= 1'b0;
      addr_q       <= '0;
      to_cnt       <= '0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      err_pulse    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_file[i] <= '0;
      end
    end else begin
      tx_start  <= 1'b0;
      wr_strobe <= 1'b0;
      err_pulse <= rx_valid && responding;

      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (rx_valid) begin
            if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
              cmd_is_write <= (rx_data == CMD_WRITE);
              state        <= GET_ADDR;
            end else begin
              tx_data <= RSP_ERR;
              state   <= SEND;
            end
          end
        end

        GET_ADDR: begin
          if (rx_valid) begin
            // An arriving byte always beats the timeout in the same cycle.
            to_cnt   <= '0;
            addr_q   <= rx_data[ADDR_WIDTH-1:0];
            addr_bad <= rx_addr_bad;
            if (cmd_is_write) begin
              state <= GET_DATA;
            end else begin
              tx_data <= rx_addr_bad ? RSP_ERR : reg_file[rx_data[ADDR_WIDTH-1:0]];
              state   <= SEND;
            end
          end else if (to_cnt == CNT_LAST) begin
            to_cnt    <= '0;
            err_pulse <= 1'b1;
            state     <= IDLE;
          end else if (to_cnt != CNT_MAX) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        GET_DATA: begin
          if (rx_valid) begin
            to_cnt <= '0;
            if (addr_bad) begin
              tx_data <= RSP_ERR;
            end else begin
              reg_file[addr_q] <= rx_data;
              tx_data          <= RSP_OK;
              wr_strobe        <= 1'b1;
              wr_addr          <= addr_q;
              wr_data          <= rx_data;
            end
            state <= SEND;
          end else if (to_cnt == CNT_LAST) begin
            to_cnt    <= '0;
            err_pulse <= 1'b1;
            state     <= IDLE;
          end else if (to_cnt != CNT_MAX) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        SEND: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            state    <= WAIT_BUSY;
          end
        end

        WAIT_BUSY: begin
          if (!tx_ready) begin
            state <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (tx_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
